elevator_call_panel: RTL and testbench
======================================

# elevator_call_panel

- Front end of the three-floor elevator: turns raw active-low hall buttons into latched calls.
- Drives the call LEDs and schedules calls in SCAN order.
- Hands the next target floor to the `movement` controller over a valid/ack handshake.
- Clears a call when the car stands at that floor with the door open.

## Interface
Parameters:
- `DB_CYCLES`, 4: consecutive stable synchronized samples required to accept a level change (debounce).
- `DB_W`, 3: debounce counter width; must hold `DB_CYCLES-1`.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `button1`, `button2`, `button3` in 1 each: raw hall buttons; 1 = released, 0 = pressed; asynchronous to `clk`.
- `floor1`, `floor2`, `floor3` in 1 each: car position from `movement`; one-hot when valid.
- `door` in 1: 1 = door open.
- `moving` in 1: 1 = car in motion.
- `req_ack` in 1: `movement` accepts `req_floor`.
- `led1`, `led2`, `led3` out 1 each: call pending for that floor.
- `req_valid` out 1: target request offered.
- `req_floor` out 2: target floor, 1..3; 0 when `req_valid` = 0.

## Operation
- **Input stage**: 2-flop synchronizer per button, reset to 1. Followed by the debounce stage (see Configuration), then a falling-edge detector producing a 1-cycle `press[i]`.
- **Calls**: `pending[i]` is set on `press[i]`. It is cleared when `floor_i && door && !moving`.
  - Clear wins over a simultaneous press: a press at the served floor with the door open is dropped.
  - `led_i` = `pending[i]`, registered.
- **Current floor (`cur`)**: updated when exactly one of `floor1..3` is high. Otherwise it holds its last value. Resets to 1.
- **Scheduler states**: IDLE, UP, DOWN.
  - IDLE: if `pending[cur]` with door closed, request `cur` and stay IDLE. Else any pending above `cur` → UP. Else any pending below → DOWN. When both above and below are pending, UP wins.
  - UP: target = lowest pending floor above `cur`. If none, go to DOWN if any below, else IDLE.
  - DOWN: target = highest pending floor below `cur`. If none, go to UP if any above, else IDLE.
- **Handshake**:
  - With no request outstanding and a target existing, assert `req_valid` with `req_floor` = target.
  - Hold both stable until an edge samples `req_valid && req_ack`. Deassert `req_valid` on the following cycle.
  - The request then stays outstanding until `cur` equals the accepted floor with `door && !moving`.
  - No new request is issued while one is outstanding. Calls arriving meanwhile only set `pending`.
- **Reset** (any time, including mid-handshake or while outstanding):
  - `pending` = 0, LEDs = 0, `req_valid` = 0, `req_floor` = 0.
  - State = IDLE, `cur` = 1, synchronizers = 1, debounce counters = 0, outstanding cleared.

## Timing
- Button first sampled low at edge N:
  - synchronized low at edge N+1;
  - with debounce, `pending` and LED set at edge N+2+`DB_CYCLES` (N+6 at default);
  - without debounce, set at edge N+2.
- `req_valid` rises 1 cycle after the scheduler sees a target with nothing outstanding, i.e. 1 cycle after `pending` sets when idle.
- Clear: `pending[i]` drops at the first edge where `floor_i && door && !moving` is sampled. The outstanding request is released on the same edge; a new `req_valid` may assert on the next edge.
- `req_ack` while `req_valid` = 0 is ignored.

## Configuration
- `CALL_PANEL_DEBOUNCE_EN` defined:
  - Per-button counter of `DB_W` bits.
  - It increments while the synchronized level differs from the debounced level and resets to 0 when they agree.
  - The debounced level flips when the count reaches `DB_CYCLES-1` and the levels still differ, so a glitch shorter than `DB_CYCLES` cycles is rejected.
- Undefined: the debounced level equals the synchronized level, no counters are built, and `DB_CYCLES`/`DB_W` are unused.

## Test plan
- Debounce EN, `DB_CYCLES`=4, car idle at floor 1: `button3` low for 10 cycles → `led3` = 1 at edge N+6; `req_valid` = 1, `req_floor` = 3 one cycle later, held until `req_ack`.
- Debounce EN: 2-cycle low glitch on `button2` → `led2` stays 0 and `req_valid` stays 0.
- Car at floor 2 with calls at floors 1 and 3: scheduler goes UP, requests 3. After `floor3` with door open, `led3` clears, then it requests 1 (DOWN).
- `floor1`=1, `door`=1, `moving`=0, `button1` pressed → `led1` never sets and no request is issued.
- Request 3 outstanding (acked), then `button2` pressed → `led2`=1 but `req_valid` stays 0 until the car reaches 3 with door open; the next request is 2.
- `rst_n` pulled low while `req_valid`=1 and `led3`=1 → all LEDs, `req_valid`, `req_floor` 0 immediately (asynchronously). After release, IDLE at floor 1.

Source files
------------

// File: rtl/elevator_call_panel_if.sv
// ---------------------------------------------------------------------------
// elevator_call_panel_if
// Bundles the hall-button, car-status, LED and target-request signals of the
// three-floor call panel.
//   button1..3 : raw active-low hall buttons (1 = released), async to clk
//   floor1..3  : car position from the movement controller, one-hot when valid
//   door       : 1 = door open
//   moving     : 1 = car in motion
//   req_ack    : movement controller accepts req_floor
//   led1..3    : call pending for that floor
//   req_valid  : target request offered
//   req_floor  : target floor 1..3, 0 when req_valid = 0
// Modports: master = environment (drives buttons/car status/ack),
//           slave  = call panel.
// ---------------------------------------------------------------------------
interface elevator_call_panel_if;
  logic       button1;
  logic       button2;
  logic       button3;
  logic       floor1;
  logic       floor2;
  logic       floor3;
  logic       door;
  logic       moving;
  logic       req_ack;
  logic       led1;
  logic       led2;
  logic       led3;
  logic       req_valid;
  logic [1:0] req_floor;

  modport master (
    output button1, button2, button3,
    output floor1, floor2, floor3,
    output door, moving, req_ack,
    input  led1, led2, led3,
    input  req_valid, req_floor
  );

  modport slave (
    input  button1, button2, button3,
    input  floor1, floor2, floor3,
    input  door, moving, req_ack,
    output led1, led2, led3,
    output req_valid, req_floor
  );
endinterface

// File: rtl/elevator_call_panel.sv
// ---------------------------------------------------------------------------
// elevator_call_panel
// Front end of the three-floor elevator. Raw hall buttons are synchronized,
// optionally debounced and edge-detected into latched calls, which drive the
// call LEDs. A SCAN scheduler (IDLE/UP/DOWN) picks the next target and hands
// it to the movement controller over a valid/ack handshake. A call is cleared
// when the car stands at that floor with the door open.
//
// Ports:
//   clk    : single clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   cp     : elevator_call_panel_if.slave (buttons, car status, LEDs, request)
//
// Parameters:
//   DB_CYCLES : stable synchronized samples needed to accept a level change
//   DB_W      : debounce counter width, must hold DB_CYCLES-1
//
// Build option:
//   CALL_PANEL_DEBOUNCE_EN : when defined, per-button debounce counters are
//   built; otherwise the debounced level is the synchronized level and
//   DB_CYCLES/DB_W are not used by any logic.
// ---------------------------------------------------------------------------
module elevator_call_panel #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  elevator_call_panel_if.slave cp
);

  typedef enum logic [1:0] { S_IDLE, S_UP, S_DOWN } sched_t;

  if (DB_CYCLES < 1 || DB_CYCLES > (1 << DB_W)) begin : g_bad_db_cfg
    $error("DB_W is too narrow to hold DB_CYCLES-1");
  end

  logic [3:1] btn_raw;
  logic [3:1] floor_in;
  logic [3:1] sync_p0;
  logic [3:1] sync_p1;
  logic [3:1] deb_lvl;
  logic [3:1] deb_dly_p2;
  logic [3:1] press;
  logic [3:1] clear;
  logic [3:1] pending;
  logic       stop;
  logic [1:0] cur;
  logic [1:0] cur_now;
  logic [1:0] above_f;
  logic [1:0] below_f;
  logic [1:0] target;
  logic       pend_cur;
  sched_t     state;
  sched_t     state_d;
  logic       req_valid_r;
  logic [1:0] req_floor_r;
  logic       out_vld;
  logic [1:0] out_floor;
  logic       done_out;
  logic       done_req;

  assign btn_raw  = {cp.button3, cp.button2, cp.button1};
  assign floor_in = {cp.floor3, cp.floor2, cp.floor1};
  assign stop     = cp.door && !cp.moving;

  // ---- stage p0/p1: two-flop button synchronizer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef CALL_PANEL_DEBOUNCE_EN
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] db_cnt [3:1];

  // ---- debounce: level flips only after DB_CYCLES differing samples ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_lvl <= '1;
      for (int i = 1; i <= 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 1; i <= 3; i++) begin
        if (sync_p1[i] == deb_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb_lvl[i] <= sync_p1[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign deb_lvl = sync_p1;
`endif

  // ---- stage p2: falling-edge detect into 1-cycle press ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) deb_dly_p2 <= '1;
    else        deb_dly_p2 <= deb_lvl;
  end

  assign press = deb_dly_p2 & ~deb_lvl;

  // Clear has priority, so a press at the served floor is dropped.
  assign clear = floor_in & {3{stop}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending | press) & ~clear;
  end

  // Car position: only a clean one-hot report moves cur; otherwise hold.
  always_comb begin
    cur_now = cur;
    case (floor_in)
      3'b001:  cur_now = 2'd1;
      3'b010:  cur_now = 2'd2;
      3'b100:  cur_now = 2'd3;
      default: cur_now = cur;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= 2'd1;
    else        cur <= cur_now;
  end

  // Nearest pending call above (lowest) and below (highest) the car.
  always_comb begin
    above_f  = 2'd0;
    below_f  = 2'd0;
    pend_cur = 1'b0;
    case (cur)
      2'd1: begin
        pend_cur = pending[1];
        above_f  = pending[2] ? 2'd2 : (pending[3] ? 2'd3 : 2'd0);
      end
      2'd2: begin
        pend_cur = pending[2];
        above_f  = pending[3] ? 2'd3 : 2'd0;
        below_f  = pending[1] ? 2'd1 : 2'd0;
      end
      2'd3: begin
        pend_cur = pending[3];
        below_f  = pending[2] ? 2'd2 : (pending[1] ? 2'd1 : 2'd0);
      end
      default: ;
    endcase
  end

  // ---- SCAN scheduler ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    target  = 2'd0;
    case (state)
      S_IDLE: begin
        if (pend_cur && !cp.door) begin
          target = cur;
        end else if (above_f != 2'd0) begin
          target  = above_f;
          state_d = S_UP;
        end else if (below_f != 2'd0) begin
          target  = below_f;
          state_d = S_DOWN;
        end
      end
      S_UP: begin
        if (above_f != 2'd0)      target  = above_f;
        else if (below_f != 2'd0) state_d = S_DOWN;
        else                      state_d = S_IDLE;
      end
      S_DOWN: begin
        if (below_f != 2'd0)      target  = below_f;
        else if (above_f != 2'd0) state_d = S_UP;
        else                      state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- request handshake and outstanding tracking ----
  assign done_out = out_vld && (cur_now == out_floor) && stop;
  // An ack that lands while the car already stands served at that floor
  // leaves nothing outstanding.
  assign done_req = (cur_now == req_floor_r) && stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_r <= 1'b0;
      req_floor_r <= 2'd0;
      out_vld     <= 1'b0;
      out_floor   <= 2'd0;
    end else if (req_valid_r) begin
      if (cp.req_ack) begin
        req_valid_r <= 1'b0;
        req_floor_r <= 2'd0;
        out_vld     <= !done_req;
        out_floor   <= req_floor_r;
      end
    end else begin
      if (done_out) out_vld <= 1'b0;
      if (!out_vld && target != 2'd0) begin
        req_valid_r <= 1'b1;
        req_floor_r <= target;
      end
    end
  end

  assign cp.led1      = pending[1];
  assign cp.led2      = pending[2];
  assign cp.led3      = pending[3];
  assign cp.req_valid = req_valid_r;
  assign cp.req_floor = req_floor_r;

endmodule

// File: tb/tb_elevator_call_panel.sv
// ---------------------------------------------------------------------------
// tb_elevator_call_panel
// Directed scenarios followed by a randomized phase. A floor-level reference
// model (call set, travel direction, accepted target) runs alongside the
// design and every cycle's LEDs and request are compared against it.
// ---------------------------------------------------------------------------
module tb_elevator_call_panel;
  localparam int DB_CYCLES = 4;
  localparam int DB_W      = 3;
`ifdef CALL_PANEL_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int PRESS_LAT = DEB_EN ? DB_CYCLES + 2 : 2;
  localparam int DIR_IDLE = 0;
  localparam int DIR_UP   = 1;
  localparam int DIR_DOWN = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  elevator_call_panel_if cp();

  elevator_call_panel #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cp   (cp)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit m_pend    [1:3];
  bit m_lvl     [1:3];
  bit m_lvl_old [1:3];
  bit m_hist    [1:3][0:15];
  int m_cur;
  int m_dir;
  bit m_rv;
  int m_rf;
  int m_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit floor_at(input int f);
    case (f)
      1:       return cp.floor1 === 1'b1;
      2:       return cp.floor2 === 1'b1;
      default: return cp.floor3 === 1'b1;
    endcase
  endfunction

  function automatic bit btn_at(input int f);
    case (f)
      1:       return cp.button1 === 1'b1;
      2:       return cp.button2 === 1'b1;
      default: return cp.button3 === 1'b1;
    endcase
  endfunction

  task automatic set_btn(input int f, input logic v);
    case (f)
      1:       cp.button1 = v;
      2:       cp.button2 = v;
      default: cp.button3 = v;
    endcase
  endtask

  task automatic set_floors(input logic [2:0] v);
    {cp.floor3, cp.floor2, cp.floor1} = v;
  endtask

  task automatic model_reset();
    for (int f = 1; f <= 3; f++) begin
      m_pend[f]    = 1'b0;
      m_lvl[f]     = 1'b1;
      m_lvl_old[f] = 1'b1;
      for (int k = 0; k < 16; k++) m_hist[f][k] = 1'b1;
    end
    m_cur = 1;
    m_dir = DIR_IDLE;
    m_rv  = 1'b0;
    m_rf  = 0;
    m_out = 0;
  endtask

  // One rising edge of the reference, using inputs as they stand at the edge.
  task automatic model_step();
    bit stop;
    bit all_diff;
    int now, nfl, up, dn, tgt, ndir, old_out;
    stop = (cp.door === 1'b1) && (cp.moving === 1'b0);
    nfl  = 0;
    now  = m_cur;
    for (int f = 1; f <= 3; f++) if (floor_at(f)) begin nfl++; now = f; end
    if (nfl != 1) now = m_cur;

    up = 0;
    for (int f = 3; f > m_cur; f--) if (m_pend[f]) up = f;
    dn = 0;
    for (int f = 1; f < m_cur; f++) if (m_pend[f]) dn = f;

    tgt  = 0;
    ndir = m_dir;
    if (m_dir == DIR_IDLE) begin
      if (m_pend[m_cur] && cp.door !== 1'b1) tgt = m_cur;
      else if (up != 0) begin tgt = up; ndir = DIR_UP; end
      else if (dn != 0) begin tgt = dn; ndir = DIR_DOWN; end
    end else if (m_dir == DIR_UP) begin
      if (up != 0) tgt = up;
      else ndir = (dn != 0) ? DIR_DOWN : DIR_IDLE;
    end else begin
      if (dn != 0) tgt = dn;
      else ndir = (up != 0) ? DIR_UP : DIR_IDLE;
    end

    old_out = m_out;
    if (m_rv) begin
      if (cp.req_ack === 1'b1) begin
        m_out = (now == m_rf && stop) ? 0 : m_rf;
        m_rv  = 1'b0;
        m_rf  = 0;
      end
    end else begin
      if (m_out != 0 && now == m_out && stop) m_out = 0;
      if (old_out == 0 && tgt != 0) begin m_rv = 1'b1; m_rf = tgt; end
    end
    m_dir = ndir;

    for (int f = 1; f <= 3; f++) begin
      if (floor_at(f) && stop) m_pend[f] = 1'b0;
      else if (m_lvl_old[f] && !m_lvl[f]) m_pend[f] = 1'b1;
    end
    m_cur = now;

    for (int f = 1; f <= 3; f++) begin
      m_lvl_old[f] = m_lvl[f];
      for (int k = 15; k > 0; k--) m_hist[f][k] = m_hist[f][k-1];
      m_hist[f][0] = btn_at(f);
      if (DEB_EN) begin
        all_diff = 1'b1;
        for (int k = 2; k < 2 + DB_CYCLES; k++) if (m_hist[f][k] == m_lvl[f]) all_diff = 1'b0;
        if (all_diff) m_lvl[f] = !m_lvl[f];
      end else begin
        m_lvl[f] = m_hist[f][1];
      end
    end
  endtask

  task automatic compare_model();
    check("led1", 32'(cp.led1), 32'(m_pend[1]));
    check("led2", 32'(cp.led2), 32'(m_pend[2]));
    check("led3", 32'(cp.led3), 32'(m_pend[3]));
    check("req_valid", 32'(cp.req_valid), 32'(m_rv));
    check("req_floor", 32'(cp.req_floor), 32'(m_rf));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n === 1'b0) model_reset();
    else                model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int f = 1; f <= 3; f++) set_btn(f, 1'b1);
    set_floors(3'b001);
    cp.door    = 1'b0;
    cp.moving  = 1'b0;
    cp.req_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_rv(input int limit);
    for (int i = 0; i < limit && cp.req_valid !== 1'b1; i++) tick();
  endtask

  task automatic hold_btn(input int f, input int n);
    set_btn(f, 1'b0);
    for (int i = 0; i < n; i++) tick();
    set_btn(f, 1'b1);
  endtask

  initial begin
    int first_led, first_rv, r;
    bit saw_led, saw_rv;
    logic [2:0] one;
    model_reset();
    do_reset();

    // Press latency from idle at floor 1, request held without ack.
    first_led = -1;
    first_rv  = -1;
    set_btn(3, 1'b0);
    for (int k = 0; k < 14; k++) begin
      tick();
      if (cp.led3 === 1'b1 && first_led < 0) first_led = k;
      if (cp.req_valid === 1'b1 && first_rv < 0) first_rv = k;
      if (k == 9) set_btn(3, 1'b1);
    end
    check("led3_latency", 32'(first_led), 32'(PRESS_LAT));
    check("req_latency", 32'(first_rv), 32'(PRESS_LAT + 1));
    check("req_floor_3", 32'(cp.req_floor), 32'd3);
    cp.req_ack = 1'b1;
    tick();
    cp.req_ack = 1'b0;
    check("ack_drops_valid", 32'(cp.req_valid), 32'd0);
    check("ack_drops_floor", 32'(cp.req_floor), 32'd0);

    // Call while a request is outstanding: lit but not requested.
    hold_btn(2, 8);
    for (int i = 0; i < 4; i++) tick();
    check("outst_led2", 32'(cp.led2), 32'd1);
    check("outst_no_req", 32'(cp.req_valid), 32'd0);
    set_floors(3'b100);
    cp.door = 1'b1;
    tick();
    check("served3_led3", 32'(cp.led3), 32'd0);
    cp.door = 1'b0;
    wait_rv(6);
    check("next_req_valid", 32'(cp.req_valid), 32'd1);
    check("next_req_floor_2", 32'(cp.req_floor), 32'd2);

    // Car at floor 2 with calls at 1 and 3: up first, then down.
    do_reset();
    set_floors(3'b010);
    tick();
    tick();
    set_btn(1, 1'b0);
    hold_btn(3, 8);
    set_btn(1, 1'b1);
    wait_rv(6);
    check("scan_up_valid", 32'(cp.req_valid), 32'd1);
    check("scan_up_floor", 32'(cp.req_floor), 32'd3);
    cp.req_ack = 1'b1;
    tick();
    cp.req_ack = 1'b0;
    set_floors(3'b100);
    cp.door = 1'b1;
    tick();
    check("scan_led3_clr", 32'(cp.led3), 32'd0);
    check("scan_led1_kept", 32'(cp.led1), 32'd1);
    cp.door = 1'b0;
    wait_rv(6);
    check("scan_down_valid", 32'(cp.req_valid), 32'd1);
    check("scan_down_floor", 32'(cp.req_floor), 32'd1);

    // Press at the floor where the car stands with the door open.
    do_reset();
    cp.door = 1'b1;
    saw_led = 1'b0;
    saw_rv  = 1'b0;
    set_btn(1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (cp.led1 === 1'b1) saw_led = 1'b1;
      if (cp.req_valid === 1'b1) saw_rv = 1'b1;
      if (i == 7) set_btn(1, 1'b1);
    end
    check("served_press_led1", 32'(saw_led), 32'd0);
    check("served_press_req", 32'(saw_rv), 32'd0);

    // Two-cycle glitch on button 2.
    do_reset();
    saw_led = 1'b0;
    saw_rv  = 1'b0;
    hold_btn(2, 2);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cp.led2 === 1'b1) saw_led = 1'b1;
      if (cp.req_valid === 1'b1) saw_rv = 1'b1;
    end
    check("glitch_led2", 32'(saw_led), DEB_EN ? 32'd0 : 32'd1);
    check("glitch_req", 32'(saw_rv), DEB_EN ? 32'd0 : 32'd1);

    // Asynchronous reset mid-handshake, then idle at floor 1.
    do_reset();
    hold_btn(3, 10);
    wait_rv(4);
    check("pre_rst_valid", 32'(cp.req_valid), 32'd1);
    check("pre_rst_led3", 32'(cp.led3), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led3", 32'(cp.led3), 32'd0);
    check("async_rst_valid", 32'(cp.req_valid), 32'd0);
    check("async_rst_floor", 32'(cp.req_floor), 32'd0);
    tick();
    rst_n = 1'b1;
    set_floors(3'b000);
    hold_btn(1, 8);
    wait_rv(8);
    check("post_rst_valid", 32'(cp.req_valid), 32'd1);
    check("post_rst_floor_1", 32'(cp.req_floor), 32'd1);

    // Randomized traffic against the reference model.
    do_reset();
    one = 3'b001;
    for (int c = 0; c < 2500; c++) begin
      for (int f = 1; f <= 3; f++)
        if ($urandom_range(0, 11) == 0) set_btn(f, !btn_at(f));
      if ($urandom_range(0, 9) == 0) begin
        r = int'($urandom_range(0, 19));
        if (r == 0)      set_floors(3'b000);
        else if (r == 1) set_floors(3'b110);
        else             set_floors(one << $urandom_range(0, 2));
      end
      if ($urandom_range(0, 5) == 0) cp.door = ~cp.door;
      if ($urandom_range(0, 7) == 0) cp.moving = ~cp.moving;
      cp.req_ack = ($urandom_range(0, 2) == 0);
      rst_n = (c == 1200) ? 1'b0 : 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
